// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction
// memory and hands {pc, instruction} pairs to decode through a 2-entry FIFO.
module inst_fetch_ctrl #(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic [1:0]        count
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [1:0]          count_q;
  logic                head_q;
  logic [ENTRY_W-1:0]  fifo_q [2];
  logic [ENTRY_W-1:0]  head_entry;
  logic                tail_idx;
  logic                pop;
  logic                enq;

  assign pop = inst_valid & inst_ready;
  assign enq = (state_q == RUN) & ~redirect_valid & ((count_q != 2'd2) | pop);

  // Slot after the last valid entry; when full with a pop this is the slot
  // being vacated by the head.
  assign tail_idx = head_q ^ count_q[0];

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // halt_req beats a simultaneous start.
      IDLE:    if (start) state_d = halt_req ? HALTED : RUN;
      RUN:     if (halt_req) state_d = HALTED;
      HALTED:  if (start && !halt_req) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q    <= redirect_addr;
        count_q <= 2'd0;
        head_q  <= 1'b0;
      end else begin
        if (enq) pc_q <= pc_q + ADDR_W'(1);
        if (pop) head_q <= ~head_q;
        count_q <= count_q + {1'b0, enq} - {1'b0, pop};
      end
    end
  end

  // NOTE: the entry storage has no reset; count gates every read, so stale
  // contents are never visible and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[tail_idx] <= {pc_q, imem_data};
  end

  assign head_entry = fifo_q[head_q];

  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst_data  = inst_valid ? head_entry[DATA_W-1:0] : '0;
  assign inst_pc    = inst_valid ? head_entry[ENTRY_W-1:DATA_W] : '0;
  assign busy       = (state_q == RUN);
  assign count      = count_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: a queue holds the {pc, instruction}
// pairs decode should receive, popped at every handshake.
module tb_inst_fetch_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              start;
  logic              halt_req;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              busy;
  logic [1:0]        count;

  int vectors     = 0;
  int miscompares = 0;
  logic [ADDR_W+DATA_W-1:0] sb [$];

  always #5 clk = ~clk;

  // Memory model: word k holds 0xA0000000 + k.
  assign imem_data = 32'hA000_0000 + {26'd0, imem_addr};

  inst_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOOT_ADDR('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy),
    .count          (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pc(input int k);
    sb.push_back({6'(k), 32'hA000_0000 + 32'(k)});
  endtask

  // Called at a negedge with inputs already set for the coming posedge.
  task automatic tick();
    logic [ADDR_W+DATA_W-1:0] e;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", 32'(inst_pc), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("pop_data", inst_data, e[DATA_W-1:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart();
    inst_ready     = 1'b0;
    start          = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    rst_n          = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0; inst_ready = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);

    // 1: streaming with ready held high
    rst_n = 1'b1; start = 1'b1; inst_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_addr", 32'(imem_addr), 32'd0);
    chk("s1_valid0", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 4; k++) expect_pc(k);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("s1_count", 32'(count), 32'd1);
      chk("s1_head_pc", 32'(inst_pc), 32'(k));
      tick();
    end
    chk("s1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: back-pressure fills the buffer, then drains in order
    restart();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 1) begin
        chk("s2_count_full", 32'(count), 32'd2);
        chk("s2_addr_hold", 32'(imem_addr), 32'd2);
      end
    end
    chk("s2_head_pc", 32'(inst_pc), 32'd0);
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) expect_pc(k);
    repeat (3) tick();
    inst_ready = 1'b0;
    chk("s2_sb_empty", 32'(sb.size()), 32'd0);
    chk("s2_head_after", 32'(inst_pc), 32'd3);

    // 3: redirect to 40 while pc=5
    restart();
    inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) expect_pc(k);
    repeat (5) tick();
    chk("s3_addr_pre", 32'(imem_addr), 32'd5);
    redirect_valid = 1'b1; redirect_addr = 6'd40;
    tick();
    redirect_valid = 1'b0;
    chk("s3_count_flush", 32'(count), 32'd0);
    chk("s3_valid_flush", 32'(inst_valid), 32'd0);
    chk("s3_addr_redir", 32'(imem_addr), 32'd40);
    tick();
    chk("s3_valid_new", 32'(inst_valid), 32'd1);
    chk("s3_pc_new", 32'(inst_pc), 32'd40);
    chk("s3_data_new", inst_data, 32'hA000_0028);
    expect_pc(40);
    tick();

    // 4: redirect to 62, PC wraps past 63
    expect_pc(41);
    redirect_valid = 1'b1; redirect_addr = 6'd62;
    tick();
    redirect_valid = 1'b0;
    expect_pc(62); expect_pc(63); expect_pc(0); expect_pc(1);
    repeat (5) tick();
    chk("s4_head_pc", 32'(inst_pc), 32'd2);
    chk("s4_addr", 32'(imem_addr), 32'd3);
    chk("s4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: halt while full and stalled, drain, resume
    inst_ready = 1'b0;
    tick();
    chk("s5_count_full", 32'(count), 32'd2);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("s5_busy_halt", 32'(busy), 32'd0);
    chk("s5_count_halt", 32'(count), 32'd2);
    chk("s5_addr_halt", 32'(imem_addr), 32'd4);
    tick();
    chk("s5_addr_frozen", 32'(imem_addr), 32'd4);
    inst_ready = 1'b1;
    expect_pc(2); expect_pc(3);
    tick();
    tick();
    chk("s5_valid_drained", 32'(inst_valid), 32'd0);
    chk("s5_count_drained", 32'(count), 32'd0);
    chk("s5_addr_drained", 32'(imem_addr), 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s5_busy_resume", 32'(busy), 32'd1);
    chk("s5_addr_resume", 32'(imem_addr), 32'd4);
    expect_pc(4);
    tick();
    chk("s5_head_resume", 32'(inst_pc), 32'd4);
    tick();
    chk("s5_head_next", 32'(inst_pc), 32'd5);

    // 6: reset mid-stream with a full buffer, then start+halt together
    inst_ready = 1'b0;
    tick();
    chk("s6_count_full", 32'(count), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s6_rst_count", 32'(count), 32'd0);
    chk("s6_rst_valid", 32'(inst_valid), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    chk("s6_rst_addr", 32'(imem_addr), 32'd0);
    chk("s6_rst_pc", 32'(inst_pc), 32'd0);
    chk("s6_rst_data", inst_data, 32'd0);
    start = 1'b1; halt_req = 1'b1;
    tick();
    start = 1'b0; halt_req = 1'b0;
    chk("s6_idle_both_busy", 32'(busy), 32'd0);
    tick();
    chk("s6_idle_both_count", 32'(count), 32'd0);
    chk("s6_idle_both_addr", 32'(imem_addr), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s6_run_busy", 32'(busy), 32'd1);
    start = 1'b1; halt_req = 1'b1;
    tick();
    start = 1'b0; halt_req = 1'b0;
    chk("s6_run_both_busy", 32'(busy), 32'd0);
    chk("s6_halt_cycle_enq", 32'(count), 32'd1);
    chk("s6_halt_addr", 32'(imem_addr), 32'd1);
    chk("s6_halt_head", 32'(inst_pc), 32'd0);
    tick();
    chk("s6_no_fetch_count", 32'(count), 32'd1);
    chk("s6_no_fetch_addr", 32'(imem_addr), 32'd1);
    inst_ready = 1'b1;
    expect_pc(0);
    tick();
    chk("s6_final_valid", 32'(inst_valid), 32'd0);
    chk("s6_final_count", 32'(count), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Fetch sequencer for the 64-word, 32-bit instruction memory; the memory is combinational read (address in, data out in the same cycle).
- Owns the program counter (PC) and drives the memory address.
- Captures {pc, instruction} pairs into a 2-entry fetch buffer and presents them to decode over a valid/ready handshake.
- Supports start/halt control and branch/jump redirect with buffer flush.

Parameters:
ADDR_W, 6, instruction memory word-address width
DATA_W, 32, instruction width
BOOT_ADDR, 0, PC value loaded at reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_addr  out  ADDR_W  word address to instruction memory
imem_data  in  DATA_W  instruction read combinationally at imem_addr
start  in  1  pulse: IDLE/HALTED -> RUN
halt_req  in  1  stop fetching after the current cycle
redirect_valid  in  1  branch/jump taken
redirect_addr  in  ADDR_W  new PC
inst_valid  out  1  buffer head valid
inst_ready  in  1  decode accepts head
inst_data  out  DATA_W  head instruction
inst_pc  out  ADDR_W  head PC
busy  out  1  state == RUN
count  out  2  buffer occupancy (0..2)

Behaviour:
- Reset applies only on a clk edge with rst_n=0. After that edge:
  - state=IDLE, pc=BOOT_ADDR, count=0
  - inst_valid=0, busy=0
  - inst_data=0, inst_pc=0
- Reset applied mid-operation discards all buffered entries and all state.
- imem_addr = pc at all times (combinational).
- States:
  - IDLE: no fetch. start -> RUN.
  - RUN: fetch. halt_req -> HALTED. Enqueue rules below apply.
  - HALTED: no fetch. start -> RUN. pc is preserved.
- If halt_req and start are both high, halt_req wins.
- pop = inst_valid & inst_ready.
- enq = (state==RUN) & !redirect_valid & (count<2 | pop).
- On enq: buffer tail <= {pc, imem_data}; pc <= pc+1, modulo 2^ADDR_W (63 wraps to 0).
- The halt_req cycle itself still enqueues if enq holds. Fetching stops from the next cycle.
- Buffer is FIFO order. inst_data and inst_pc always show the head entry, and read 0 when count=0.
- Simultaneous pop and enq when full (count=2): count stays 2, head advances, new entry goes to the tail.
- Redirect (any state), that cycle:
  - buffer flushed, count <= 0
  - pc <= redirect_addr
  - no enqueue
  - any pop that cycle is still treated as consumed
  - state is unchanged
- Redirect has priority over enq.
- After a redirect in RUN, the next cycle fetches redirect_addr.
- Latency:
  - start sampled at edge N -> RUN during cycle N+1 with imem_addr=pc.
  - Entry enqueued at edge N+1; inst_valid=1 during cycle N+2.
  - Redirect to first valid instruction: 2 cycles.
- Back-pressure: while inst_ready=0 and count=2, pc holds and imem_addr is stable.
- In HALTED, the buffer drains normally through pops.
- inst_valid = (count != 0).

Test Plan:
Bench memory model for all scenarios: word k = 0xA0000000 + k.
1. Reset, then start pulse, inst_ready=1 held -> from cycle 2 after start, one entry per cycle with inst_pc=0,1,2,3 and inst_data=0xA0000000..0xA0000003; count stays 1.
2. Start, inst_ready=0 for 5 cycles -> count goes to 2 and stays; imem_addr holds at 2; then ready=1 -> entries pc 0,1,2 come out in order, none lost or duplicated.
3. Steady stream, redirect_valid with redirect_addr=40 at pc=5 -> count=0 next cycle; next valid entry is inst_pc=40, data 0xA0000028, two cycles after the redirect.
4. redirect_addr=62, stream continues -> inst_pc sequence is 62, 63, 0, 1 (wrap-around).
5. halt_req while count=2 and ready=0 -> busy=0 next cycle, pc frozen; ready=1 drains 2 entries, then inst_valid=0; start resumes at the preserved pc.
6. rst_n=0 for one edge mid-stream with count=2 -> after the edge: count=0, inst_valid=0, busy=0, imem_addr=0; start and halt_req asserted together in IDLE/RUN -> ends in HALTED.
